// File: rtl/seq_stepper_pkg.sv
// Shared definitions for the six-position display sequencer.
// Position codes are stored as {state[3], state[2], state[1]}.
// Codes with state[1] = 0 and state[2] = 0 (3'b000, 3'b100) are illegal.
package seq_stepper_pkg;

    // Position encodings for state[3:1]
    localparam logic [2:0] POS_A = 3'b101;
    localparam logic [2:0] POS_B = 3'b001;
    localparam logic [2:0] POS_C = 3'b110;
    localparam logic [2:0] POS_D = 3'b011;
    localparam logic [2:0] POS_E = 3'b111;
    localparam logic [2:0] POS_F = 3'b010;

    // Displayed values
    localparam logic [2:0] VAL_3 = 3'd3;
    localparam logic [2:0] VAL_5 = 3'd5;
    localparam logic [2:0] VAL_6 = 3'd6;
    localparam logic [2:0] VAL_2 = 3'd2;

    localparam int NUM_POS = 6;

    // Position index (0 = A .. 5 = F) to state[3:1] encoding.
    // Out-of-range indices fall back to A.
    function automatic logic [2:0] pos_encode(input logic [2:0] idx);
        logic [2:0] code;
        case (idx)
            3'd0:    code = POS_A;
            3'd1:    code = POS_B;
            3'd2:    code = POS_C;
            3'd3:    code = POS_D;
            3'd4:    code = POS_E;
            3'd5:    code = POS_F;
            default: code = POS_A;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/seq_stepper_next.sv
// Combinational next-position logic for seq_stepper.
// Maps (state[3:1], dir) to the following position. An illegal code always
// recovers to A, whatever the direction. Bit 0 (spare) passes straight through.
// The wrap output flags an F->A (up) or A->F (down) transition.
module seq_next
    import seq_stepper_pkg::*;
(
    input  logic [3:0] state,
    input  logic       dir,
    output logic [3:0] next_state,
    output logic       wrap
);

    logic [2:0] cur_s;
    logic [2:0] nxt_s;

    assign cur_s = state[3:1];

    // Sequence successor/predecessor lookup with illegal-code recovery
    always_comb begin
        nxt_s = POS_A;
        wrap  = 1'b0;
        case (cur_s)
            POS_A: begin
                if (dir) begin
                    nxt_s = POS_F;
                    wrap  = 1'b1;
                end else begin
                    nxt_s = POS_B;
                    wrap  = 1'b0;
                end
            end
            POS_B: begin
                if (dir) begin
                    nxt_s = POS_A;
                end else begin
                    nxt_s = POS_C;
                end
            end
            POS_C: begin
                if (dir) begin
                    nxt_s = POS_B;
                end else begin
                    nxt_s = POS_D;
                end
            end
            POS_D: begin
                if (dir) begin
                    nxt_s = POS_C;
                end else begin
                    nxt_s = POS_E;
                end
            end
            POS_E: begin
                if (dir) begin
                    nxt_s = POS_D;
                end else begin
                    nxt_s = POS_F;
                end
            end
            POS_F: begin
                if (dir) begin
                    nxt_s = POS_E;
                    wrap  = 1'b0;
                end else begin
                    nxt_s = POS_A;
                    wrap  = 1'b1;
                end
            end
            default: begin
                // Illegal code (only reachable by an upset): go home, no wrap
                nxt_s = POS_A;
                wrap  = 1'b0;
            end
        endcase
    end

    assign next_state = {nxt_s, state[0]};

endmodule

// File: rtl/seq_stepper.sv
// Six-position sequence stepper (A..F, displaying 3,3,3,5,6,2).
// Owns the state register feeding the downstream next-state decoder and
// display. Steps on a rising edge of step_btn or on each prescaler tick when
// auto_en is set; hold freezes state, prescaler and button edge history.
// Build option SEQ_SYNC_EN: step_btn, dir and auto_en pass through a 2-flop
// synchronizer first (manual step becomes visible 3 cycles after the input rises).
module seq_stepper
    import seq_stepper_pkg::*;
#(
    parameter int PRESCALE = 4,
    parameter int INIT_POS = 0
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step_btn,
    input  logic       dir,
    input  logic       auto_en,
    input  logic       hold,
    output logic [3:0] state,
    output logic [2:0] value,
    output logic [5:0] pos,
    output logic       step_done,
    output logic       wrap
);

    localparam int            CW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] CNT_MAX    = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
    localparam logic [3:0]    INIT_STATE = {pos_encode(3'(INIT_POS)), 1'b0};

    logic          btn_s;
    logic          dir_s;
    logic          auto_s;

    logic          btn_q_r;
    logic [CW-1:0] cnt_r;
    logic [3:0]    state_r;
    logic          step_done_r;
    logic          wrap_r;

    logic          req_s;
    logic          tick_s;
    logic          step_s;
    logic [3:0]    next_state_s;
    logic          next_wrap_s;

`ifdef SEQ_SYNC_EN
    logic [1:0] btn_sync_r;
    logic [1:0] dir_sync_r;
    logic [1:0] auto_sync_r;

    // Two-stage synchronizers for the asynchronous control inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_sync_r  <= 2'b00;
            dir_sync_r  <= 2'b00;
            auto_sync_r <= 2'b00;
        end else begin
            btn_sync_r  <= {btn_sync_r[0], step_btn};
            dir_sync_r  <= {dir_sync_r[0], dir};
            auto_sync_r <= {auto_sync_r[0], auto_en};
        end
    end

    assign btn_s  = btn_sync_r[1];
    assign dir_s  = dir_sync_r[1];
    assign auto_s = auto_sync_r[1];
`else
    assign btn_s  = step_btn;
    assign dir_s  = dir;
    assign auto_s = auto_en;
`endif

    // Step request: button rising edge or prescaler tick, both masked by hold
    always_comb begin
        req_s  = btn_s & ~btn_q_r & ~hold;
        tick_s = auto_s & ~hold & (cnt_r == CNT_MAX);
        step_s = req_s | tick_s;
    end

    seq_next u_next (
        .state      (state_r),
        .dir        (dir_s),
        .next_state (next_state_s),
        .wrap       (next_wrap_s)
    );

    // Button edge history; frozen under hold so a held press survives release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q_r <= 1'b0;
        end else if (hold) begin
            btn_q_r <= btn_q_r;
        end else begin
            btn_q_r <= btn_s;
        end
    end

    // Auto-step prescaler: parked at 0 while auto is off, frozen under hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= CNT_ZERO;
        end else if (hold) begin
            cnt_r <= cnt_r;
        end else if (!auto_s) begin
            cnt_r <= CNT_ZERO;
        end else if (tick_s) begin
            cnt_r <= CNT_ZERO;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    // State register and step/wrap strobes aligned with the new state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= INIT_STATE;
            step_done_r <= 1'b0;
            wrap_r      <= 1'b0;
        end else if (step_s) begin
            state_r     <= next_state_s;
            step_done_r <= 1'b1;
            wrap_r      <= next_wrap_s;
        end else begin
            state_r     <= state_r;
            step_done_r <= 1'b0;
            wrap_r      <= 1'b0;
        end
    end

    // Display value and one-hot position decoded from the state register
    always_comb begin
        value = VAL_3;
        pos   = 6'b000000;
        case (state_r[3:1])
            POS_A: begin
                value = VAL_3;
                pos   = 6'b000001;
            end
            POS_B: begin
                value = VAL_3;
                pos   = 6'b000010;
            end
            POS_C: begin
                value = VAL_3;
                pos   = 6'b000100;
            end
            POS_D: begin
                value = VAL_5;
                pos   = 6'b001000;
            end
            POS_E: begin
                value = VAL_6;
                pos   = 6'b010000;
            end
            POS_F: begin
                value = VAL_2;
                pos   = 6'b100000;
            end
            default: begin
                value = VAL_3;
                pos   = 6'b000000;
            end
        endcase
    end

    assign state     = state_r;
    assign step_done = step_done_r;
    assign wrap      = wrap_r;

endmodule

// File: tb/tb_seq_stepper.sv
// Self-checking bench for seq_stepper: directed steps plus randomized traffic,
// compared every cycle against a position-index reference model.
module tb_seq_stepper;

    localparam int PRESCALE = 4;
    localparam int INIT_POS = 0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       step_btn;
    logic       dir;
    logic       auto_en;
    logic       hold;
    logic [3:0] state;
    logic [2:0] value;
    logic [5:0] pos;
    logic       step_done;
    logic       wrap;

    seq_stepper #(.PRESCALE(PRESCALE), .INIT_POS(INIT_POS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .step_btn  (step_btn),
        .dir       (dir),
        .auto_en   (auto_en),
        .hold      (hold),
        .state     (state),
        .value     (value),
        .pos       (pos),
        .step_done (step_done),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Encoding table, one list per state bit, positions A..F
    bit S1[6]   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    bit S2[6]   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    bit S3[6]   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int VALS[6] = '{3, 3, 3, 5, 6, 2};

    // Reference model
    int         m_idx;        // 0..5, or -1 while illegal
    logic [3:0] m_illegal_vec;
    bit         m_btnq;
    int         m_cnt;
    bit         m_done;
    bit         m_wrap;
    bit         pb[2];
    bit         pd[2];
    bit         pa[2];
    int         n_steps = 0;

    function automatic logic [3:0] exp_state();
        if (m_idx < 0) return m_illegal_vec;
        return {S3[m_idx], S2[m_idx], S1[m_idx], 1'b0};
    endfunction

    function automatic int exp_value();
        if (m_idx < 0) return 3;
        return VALS[m_idx];
    endfunction

    function automatic logic [5:0] exp_pos();
        logic [5:0] one;
        one = 6'b000001;
        if (m_idx < 0) return 6'b000000;
        return one << m_idx;
    endfunction

    task automatic reset_model();
        m_idx  = INIT_POS;
        m_btnq = 1'b0;
        m_cnt  = 0;
        m_done = 1'b0;
        m_wrap = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pb[i] = 1'b0;
            pd[i] = 1'b0;
            pa[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        bit eb, ed, ea, req, tk;
`ifdef SEQ_SYNC_EN
        eb = pb[1]; ed = pd[1]; ea = pa[1];
        pb[1] = pb[0]; pd[1] = pd[0]; pa[1] = pa[0];
        pb[0] = step_btn; pd[0] = dir; pa[0] = auto_en;
`else
        eb = step_btn; ed = dir; ea = auto_en;
`endif
        req = eb && !m_btnq && !hold;
        tk  = ea && !hold && (m_cnt == PRESCALE - 1);
        if (!hold) begin
            m_btnq = eb;
            m_cnt  = ea ? (m_cnt + 1) % PRESCALE : 0;
        end
        m_done = 1'b0;
        m_wrap = 1'b0;
        if (req || tk) begin
            m_done = 1'b1;
            n_steps++;
            if (m_idx < 0) begin
                m_idx = 0;
            end else if (ed) begin
                m_wrap = (m_idx == 0);
                m_idx  = (m_idx + 5) % 6;
            end else begin
                m_wrap = (m_idx == 5);
                m_idx  = (m_idx + 1) % 6;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"}, 32'(state), 32'(exp_state()));
        chk({tag, ".value"}, 32'(value), 32'(exp_value()));
        chk({tag, ".pos"}, 32'(pos), 32'(exp_pos()));
        chk({tag, ".step_done"}, 32'(step_done), 32'(m_done));
        chk({tag, ".wrap"}, 32'(wrap), 32'(m_wrap));
        chk({tag, ".prescale"}, 32'(dut.cnt_r), 32'(m_cnt));
    endtask

    task automatic cyc(input bit b, input bit d, input bit a, input bit h, input string tag);
        step_btn = b; dir = d; auto_en = a; hold = h;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    int         t1_vals[6] = '{3, 3, 5, 6, 2, 3};
    int         s0;
    int         pulses;
    logic [3:0] saved_state;

    initial begin
        rst_n = 1'b0; step_btn = 1'b0; dir = 1'b0; auto_en = 1'b0; hold = 1'b0;
        reset_model();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Six single-cycle pulses upward: B,C,D,E,F,A
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, "up_pulse");
`ifndef SEQ_SYNC_EN
            chk("up_value", 32'(value), 32'(t1_vals[i]));
            chk("up_wrap", 32'(wrap), (i == 5) ? 32'd1 : 32'd0);
            chk("up_done", 32'(step_done), 32'd1);
`endif
            cyc(1'b0, 1'b0, 1'b0, 1'b0, "up_idle");
        end
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, "settle");

        // One pulse downward from A: F with wrap
        cyc(1'b1, 1'b1, 1'b0, 1'b0, "down_pulse");
`ifndef SEQ_SYNC_EN
        chk("down_state", 32'(state), 32'h4);
        chk("down_value", 32'(value), 32'd2);
        chk("down_pos", 32'(pos), 32'h20);
        chk("down_wrap", 32'(wrap), 32'd1);
`endif
        repeat (4) cyc(1'b0, 1'b1, 1'b0, 1'b0, "down_idle");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "back_up");
        repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b0, "back_idle");

        // Button held 10 cycles: exactly one step
        s0 = n_steps;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, "held");
            pulses += int'(step_done);
        end
        repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b0, "held_rel");
        chk("held_steps", 32'(n_steps - s0), 32'd1);
        chk("held_pulses", 32'(pulses), 32'd1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, "to_a");
        repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b0, "to_a_idle");

        // Auto mode from A with a coincident manual pulse on cycle 8
        s0 = n_steps;
        for (int k = 1; k <= 12; k++) begin
            cyc(k == 8, 1'b0, 1'b1, 1'b0, "auto");
        end
`ifndef SEQ_SYNC_EN
        chk("auto_state_d", 32'(state), 32'h6);
        chk("auto_steps", 32'(n_steps - s0), 32'd3);
`endif

        // Hold across a pending tick and a full button pulse
        repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b0, "pre_hold");
        saved_state = state;
        cyc(1'b0, 1'b0, 1'b1, 1'b1, "hold");
        cyc(1'b1, 1'b0, 1'b1, 1'b1, "hold_btn");
        cyc(1'b0, 1'b0, 1'b1, 1'b1, "hold");
        cyc(1'b0, 1'b0, 1'b1, 1'b1, "hold");
        chk("hold_state", 32'(state), 32'(saved_state));
        repeat (6) cyc(1'b0, 1'b0, 1'b1, 1'b0, "post_hold");
        repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b0, "auto_off");

        // Upset to an illegal code, then step down: recovers to A
        force dut.state_r = 4'b0000;
        m_idx = -1;
        m_illegal_vec = 4'b0000;
        #1;
        check_all("illegal");
        #1;
        release dut.state_r;
        cyc(1'b1, 1'b1, 1'b0, 1'b0, "recover");
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0, "recover_idle");
        chk("recover_state", 32'(state), 32'hA);

`ifdef SEQ_SYNC_EN
        // Synchronized build: step appears on the third edge after the rise
        saved_state = state;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "sync1");
        chk("sync1_state", 32'(state), 32'(saved_state));
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "sync2");
        chk("sync2_state", 32'(state), 32'(saved_state));
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "sync3");
        chk("sync3_done", 32'(step_done), 32'd1);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, "sync_idle");
`endif

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 3) == 0), $urandom_range(0, 1),
                ((i / 100) % 2 == 1), ($urandom_range(0, 7) == 0), "rand");
        end

        // Asynchronous reset right after a step
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        reset_model();
        check_all("mid_reset");
        chk("mid_reset_done", 32'(step_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step_btn = 1'b0;
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
